// File: rtl/fu_issue_arb_pkg.sv
// rtl/fu_issue_arb_pkg.sv - shared widths, message layout and sizing helpers for fu_issue_arbiter
package fu_issue_arb_pkg;

    // Default configuration of the BlimpV7 execute-pipe arbiter
    localparam int lp_default_num_req      = 4;
    localparam int lp_default_msg_bits     = 48;
    localparam int lp_default_max_inflight = 4;

    // Default requester payload layout (opaque to the arbiter, packed by the issue queues)
    localparam int lp_seq_bits  = 8;
    localparam int lp_preg_bits = 7;
    localparam int lp_op_bits   = 5;
    localparam int lp_imm_bits  = 14;

    typedef struct packed {
        logic [lp_seq_bits-1:0]  seq;
        logic [lp_preg_bits-1:0] prd;
        logic [lp_preg_bits-1:0] prs1;
        logic [lp_preg_bits-1:0] prs2;
        logic [lp_op_bits-1:0]   op;
        logic [lp_imm_bits-1:0]  imm;
    } fu_msg_t;

    // Width of a requester ID; never narrower than one bit
    function automatic int id_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold 0..n inclusive
    function automatic int credit_bits(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_rr_pick.sv
// rtl/fu_issue_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module fu_issue_arbiter_rr_pick
    import fu_issue_arb_pkg::*;
#(
    parameter int p_num_req = 4,
    parameter int p_id_bits = id_bits(p_num_req)
) (
    input  logic [p_num_req-1:0] req,
    input  logic [p_id_bits-1:0] ptr,
    input  logic                 en,
    output logic [p_num_req-1:0] gnt,
    output logic [p_id_bits-1:0] gnt_id
);

    // Scan ptr, ptr+1, ... (mod p_num_req) and take the first active request
    always_comb begin
        logic                 found;
        logic [p_id_bits-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        if (en) begin
            for (int k = 0; k < p_num_req; k++) begin
                idx = p_id_bits'((int'(ptr) + k) % p_num_req);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/fu_issue_arbiter.sv
// rtl/fu_issue_arbiter.sv - round-robin, credit-limited issue arbiter for a shared FU (perf option: FU_ISSUE_ARBITER_PERF_EN)
module fu_issue_arbiter
    import fu_issue_arb_pkg::*;
#(
    parameter  int p_num_req      = lp_default_num_req,
    parameter  int p_msg_bits     = lp_default_msg_bits,
    parameter  int p_max_inflight = lp_default_max_inflight,
    localparam int p_id_bits      = id_bits(p_num_req),
    localparam int p_cred_bits    = credit_bits(p_max_inflight)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [p_num_req-1:0]            req_val,
    output logic [p_num_req-1:0]            req_rdy,
    input  logic [p_num_req*p_msg_bits-1:0] req_msg,
    output logic                            fu_val,
    input  logic                            fu_rdy,
    output logic [p_msg_bits-1:0]           fu_msg,
    output logic [p_id_bits-1:0]            fu_id,
    input  logic                            cmp_val,
    input  logic [p_id_bits-1:0]            cmp_id,
    output logic [p_num_req-1:0]            cmp_out_val,
    output logic [p_cred_bits-1:0]          inflight
`ifdef FU_ISSUE_ARBITER_PERF_EN
    ,
    output logic [31:0]                     perf_grants,
    output logic [31:0]                     perf_stall
`endif
);

    localparam logic [p_cred_bits-1:0] lp_max_cred = p_cred_bits'(p_max_inflight);
    localparam logic [p_id_bits-1:0]   lp_last_id  = p_id_bits'(p_num_req - 1);

    logic                   fu_val_q, fu_val_d;
    logic [p_msg_bits-1:0]  fu_msg_q, fu_msg_d;
    logic [p_id_bits-1:0]   fu_id_q, fu_id_d;
    logic [p_id_bits-1:0]   ptr_q, ptr_d;
    logic [p_cred_bits-1:0] inflight_q, inflight_d;

    logic                   slot_free;
    logic                   can_grant;
    logic                   grant;
    logic                   cmp_eff;
    logic [p_num_req-1:0]   gnt;
    logic [p_id_bits-1:0]   gnt_id;
    logic [p_msg_bits-1:0]  msg_sel;

    // Grant is allowed when the output slot drains this cycle and a credit is free.
    // Held off during reset so a requester never sees a grant that the register drops.
    always_comb begin
        slot_free = !fu_val_q || fu_rdy;
        can_grant = rst_n && slot_free && (inflight_q < lp_max_cred);
    end

    fu_issue_arbiter_rr_pick #(
        .p_num_req (p_num_req),
        .p_id_bits (p_id_bits)
    ) u_rr_pick (
        .req    (req_val),
        .ptr    (ptr_q),
        .en     (can_grant),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // One-hot payload select; kept off the req_rdy path
    always_comb begin
        msg_sel = '0;
        for (int i = 0; i < p_num_req; i++) begin
            if (gnt[i]) begin
                msg_sel = req_msg[i*p_msg_bits +: p_msg_bits];
            end
        end
    end

    // Next-state for the output register and round-robin pointer
    always_comb begin
        grant    = |gnt;
        fu_val_d = fu_val_q;
        fu_msg_d = fu_msg_q;
        fu_id_d  = fu_id_q;
        ptr_d    = ptr_q;
        if (grant) begin
            fu_val_d = 1'b1;
            fu_msg_d = msg_sel;
            fu_id_d  = gnt_id;
            ptr_d    = (gnt_id == lp_last_id) ? '0 : gnt_id + 1'b1;
        end else if (fu_rdy) begin
            fu_val_d = 1'b0;
        end
    end

    // Credit counter: grant takes one, a completion returns one; completions with nothing in flight are dropped
    always_comb begin
        cmp_eff    = cmp_val && (inflight_q != '0);
        inflight_d = inflight_q;
        case ({grant, cmp_eff})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Completion steering: IDs beyond the requester range select nothing
    always_comb begin
        cmp_out_val = '0;
        for (int i = 0; i < p_num_req; i++) begin
            cmp_out_val[i] = cmp_val && (cmp_id == p_id_bits'(i));
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_val_q   <= 1'b0;
            fu_msg_q   <= '0;
            fu_id_q    <= '0;
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            fu_val_q   <= fu_val_d;
            fu_msg_q   <= fu_msg_d;
            fu_id_q    <= fu_id_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign req_rdy  = gnt;
    assign fu_val   = fu_val_q;
    assign fu_msg   = fu_msg_q;
    assign fu_id    = fu_id_q;
    assign inflight = inflight_q;

`ifdef FU_ISSUE_ARBITER_PERF_EN
    logic [31:0] perf_grants_q;
    logic [31:0] perf_stall_q;

    // Wrapping counters of grants and of cycles where someone asked but nobody was granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (grant) begin
                perf_grants_q <= perf_grants_q + 32'd1;
            end
            if (|req_val && !grant) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb/tb_fu_issue_arbiter.sv - scoreboard bench for fu_issue_arbiter (4 requesters, 2 credits)
module tb_fu_issue_arbiter;
    import fu_issue_arb_pkg::*;

    localparam int N    = 4;
    localparam int W    = 48;
    localparam int MAXI = 2;
    localparam int IDB  = id_bits(N);
    localparam int CB   = credit_bits(MAXI);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_val;
    logic [N-1:0]    req_rdy;
    logic [N*W-1:0]  req_msg;
    logic            fu_val;
    logic            fu_rdy;
    logic [W-1:0]    fu_msg;
    logic [IDB-1:0]  fu_id;
    logic            cmp_val;
    logic [IDB-1:0]  cmp_id;
    logic [N-1:0]    cmp_out_val;
    logic [CB-1:0]   inflight;
`ifdef FU_ISSUE_ARBITER_PERF_EN
    logic [31:0]     perf_grants;
    logic [31:0]     perf_stall;
`endif

    logic [W-1:0]       msgs [N];
    logic [IDB+W-1:0]   sb_q [$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic               spur_q   = 1'b0;

    fu_issue_arbiter #(
        .p_num_req      (N),
        .p_msg_bits     (W),
        .p_max_inflight (MAXI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_msg     (req_msg),
        .fu_val      (fu_val),
        .fu_rdy      (fu_rdy),
        .fu_msg      (fu_msg),
        .fu_id       (fu_id),
        .cmp_val     (cmp_val),
        .cmp_id      (cmp_id),
        .cmp_out_val (cmp_out_val),
        .inflight    (inflight)
`ifdef FU_ISSUE_ARBITER_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        req_msg = '0;
        for (int i = 0; i < N; i++) begin
            req_msg[i*W +: W] = msgs[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id);
        sb_q.push_back({IDB'(id), msgs[id]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every op the unit accepts must be the next expected one
    always @(negedge clk) begin
        logic [IDB+W-1:0] exp_op;
        if (rst_n && fu_val && fu_rdy) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_op: got id=%0d msg=%h expected none", fu_id, fu_msg);
            end else begin
                exp_op = sb_q.pop_front();
                check("sb_fu_id", 64'(fu_id), 64'(exp_op[W +: IDB]));
                check("sb_fu_msg", 64'(fu_msg), 64'(exp_op[W-1:0]));
            end
        end
    end

    // Completion with nothing in flight and no grant must leave the counter at zero
    always @(negedge clk) begin
        if (spur_q) begin
            check("spurious_cmp_no_underflow", 64'(inflight), 64'd0);
        end
        spur_q <= rst_n && cmp_val && (inflight == '0) && (req_rdy == '0);
    end

    initial begin
        msgs[0] = 48'h0123_4567_89AB;
        msgs[1] = 48'hFEDC_BA98_7654;
        msgs[2] = 48'h5A5A_A5A5_0F0F;
        msgs[3] = 48'h0000_FFFF_1234;
        rst_n   = 1'b0;
        req_val = 4'b1111;
        fu_rdy  = 1'b1;
        cmp_val = 1'b1;
        cmp_id  = 2'd2;

        // Reset held with requests and completions active
        repeat (3) step();
        check("rst_fu_val", 64'(fu_val), 64'd0);
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_fu_id", 64'(fu_id), 64'd0);
        check("rst_fu_msg", 64'(fu_msg), 64'd0);

        // Release: first grant is requester 0
        rst_n   = 1'b1;
        cmp_val = 1'b0;
        #1;
        check("first_grant_rdy", 64'(req_rdy), 64'b0001);
        push(0);

        // Round robin with a completion each cycle: 0,1,2,3,0
        for (int k = 1; k <= 4; k++) begin
            step();
            cmp_val = 1'b1;
            cmp_id  = IDB'(k - 1);
            #1;
            check("rr_cmp_out_val", 64'(cmp_out_val), 64'(4'b0001 << (k - 1)));
            check("rr_req_rdy", 64'(req_rdy), 64'(4'b0001 << (k % 4)));
            check("rr_inflight", 64'(inflight), 64'd1);
            push(k % 4);
        end
        step();
        req_val = 4'b0000;
        cmp_id  = 2'd0;
        step();
        check("rr_drain_inflight", 64'(inflight), 64'd0);
        check("rr_drain_fu_val", 64'(fu_val), 64'd0);
        step();
        check("spur_inflight", 64'(inflight), 64'd0);
        cmp_val = 1'b0;

        // Backpressure: requester 2 alone, unit stalls 3 cycles
        req_val = 4'b0100;
        fu_rdy  = 1'b0;
        #1;
        check("bp_req_rdy", 64'(req_rdy), 64'b0100);
        push(2);
        step();
        msgs[2] = 48'hDEAD_BEEF_0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_fu_val", 64'(fu_val), 64'd1);
            check("bp_fu_id", 64'(fu_id), 64'd2);
            check("bp_fu_msg", 64'(fu_msg), 64'h5A5A_A5A5_0F0F);
            check("bp_req_rdy_stall", 64'(req_rdy), 64'd0);
            step();
        end
        fu_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 64'(req_rdy), 64'b0100);
        push(2);
        step();
        check("bp_inflight", 64'(inflight), 64'd2);
        check("bp_credit_block", 64'(req_rdy), 64'd0);
        req_val = 4'b0000;
        cmp_val = 1'b1;
        cmp_id  = 2'd2;
        step();
        step();
        cmp_val = 1'b0;
        check("bp_drain_inflight", 64'(inflight), 64'd0);

        // Credits: two grants then blocked
        req_val = 4'b1111;
        #1;
        check("cr_rdy0", 64'(req_rdy), 64'b1000);
        push(3);
        step();
        check("cr_rdy1", 64'(req_rdy), 64'b0001);
        push(0);
        step();
        check("cr_full_rdy", 64'(req_rdy), 64'd0);
        check("cr_full_inflight", 64'(inflight), 64'd2);
        step();
        check("cr_full_rdy_idle", 64'(req_rdy), 64'd0);
        check("cr_full_fu_val", 64'(fu_val), 64'd0);
        cmp_val = 1'b1;
        cmp_id  = 2'd1;
        #1;
        check("cr_cmp_out_val", 64'(cmp_out_val), 64'b0010);
        check("cr_no_comb_path", 64'(req_rdy), 64'd0);
        step();
        cmp_val = 1'b0;
        #1;
        check("cr_regrant_rdy", 64'(req_rdy), 64'b0010);
        push(1);
        step();
        check("cr_refull_inflight", 64'(inflight), 64'd2);

        // Simultaneous grant and completion at inflight=1
        req_val = 4'b0000;
        cmp_val = 1'b1;
        cmp_id  = 2'd3;
        step();
        check("sim_pre_inflight", 64'(inflight), 64'd1);
        req_val = 4'b0001;
        cmp_id  = 2'd0;
        #1;
        check("sim_rdy", 64'(req_rdy), 64'b0001);
        push(0);
        step();
        check("sim_inflight_hold", 64'(inflight), 64'd1);
        req_val = 4'b0000;
        step();
        check("sim_drain_inflight", 64'(inflight), 64'd0);
        step();
        check("sim_spur_inflight", 64'(inflight), 64'd0);
        cmp_val = 1'b0;

        // Async reset mid-stream with a stalled op
        req_val = 4'b0010;
        fu_rdy  = 1'b0;
        #1;
        check("ar_rdy", 64'(req_rdy), 64'b0010);
        step();
        req_val = 4'b0000;
        check("ar_pre_fu_val", 64'(fu_val), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_fu_val_drop", 64'(fu_val), 64'd0);
        check("ar_inflight", 64'(inflight), 64'd0);
        step();
        rst_n   = 1'b1;
        req_val = 4'b1111;
        fu_rdy  = 1'b1;
        #1;
        check("ar_ptr_reset_rdy", 64'(req_rdy), 64'b0001);
        check("ar_post_inflight", 64'(inflight), 64'd0);
        push(0);
        step();
        req_val = 4'b0000;
        check("ar_post_fu_id", 64'(fu_id), 64'd0);
        repeat (3) step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
- Shares one execute functional unit (the ALU/shift pipe that runs SLLI and friends) among p_num_req issue requesters.
- Picks one request per cycle by round-robin and registers it toward the unit, tagged with the requester ID.
- Limits in-flight ops with a credit counter and steers completions back to the originating requester.
- Sits between the per-queue issue stages and the shared execute stage in the BlimpV7 back end.

Parameters:
- p_num_req, 4, number of issue requesters (≥2)
- p_msg_bits, 48, opaque request payload width (seq num, phys regs, op, imm packed by the requester)
- p_max_inflight, 4, maximum granted ops not yet completed (≥1)
- (derived) p_id_bits = max(1, $clog2(p_num_req))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_val  in  p_num_req  per-requester request valid
- req_rdy  out  p_num_req  per-requester grant; one-hot or zero, combinational
- req_msg  in  p_num_req*p_msg_bits  payloads; requester i at bits [i*p_msg_bits +: p_msg_bits]
- fu_val  out  1  registered op valid to the unit
- fu_rdy  in  1  unit accepts the op
- fu_msg  out  p_msg_bits  registered payload
- fu_id  out  p_id_bits  registered requester ID
- cmp_val  in  1  completion pulse from the unit
- cmp_id  in  p_id_bits  requester ID of the completing op
- cmp_out_val  out  p_num_req  one-hot completion to the requester: bit cmp_id set when cmp_val
- inflight  out  $clog2(p_max_inflight+1)  current in-flight count

Behaviour:
- Reset (async, rst_n=0): fu_val=0, fu_msg=0, fu_id=0, round-robin pointer=0, inflight=0. The reset is asynchronous at any time, including mid-operation: a pending fu op is dropped, and completions arriving during reset are ignored. Outputs are stable the first cycle after deassertion.
- Slot free condition: slot_free = !fu_val || fu_rdy.
- Grant condition: can_grant = slot_free && (inflight < p_max_inflight).
- Grant selection: when can_grant, req_rdy has a one-hot at the first i with req_val[i]=1, scanning ptr, ptr+1, … mod p_num_req. Otherwise req_rdy=0.
- req_rdy depends only on req_val, ptr, fu_val, fu_rdy and inflight. It must not depend on req_msg.
- On a grant to i at edge t: fu_val=1, fu_msg=req_msg[i], fu_id=i, ptr=(i+1) mod p_num_req. Latency is 1 cycle: fu_val is visible in cycle t+1.
- On fu_rdy with no new grant: fu_val=0; fu_msg and fu_id hold.
- While fu_val=1 and fu_rdy=0: fu_msg and fu_id stay stable and ptr holds.
- Credit counting: inflight increments on a grant and decrements on cmp_val. A grant and cmp_val in the same cycle leave it unchanged.
- Credit exhaustion: at inflight==p_max_inflight no grant is issued. A completion that frees the last credit permits a grant in the next cycle, not the same cycle; there is no combinational cmp_val→req_rdy path.
- Spurious completion: cmp_val with inflight==0 is ignored (no underflow). The bench checks for it with an assertion.
- cmp_id ≥ p_num_req: no cmp_out_val bit is set.
- No internal states beyond ptr, the output register and inflight.

Optional Feature:
- Macro: FU_ISSUE_ARBITER_PERF_EN.
- With the macro defined, two 32-bit wrapping counters are added, both cleared by rst_n:
  - perf_grants out: increments on every grant.
  - perf_stall out: increments on each cycle with |req_val && no grant.
- Without the macro, these ports and their logic do not exist.

Decomposition:
- Shared package fu_issue_arb_pkg holds:
  - function id_bits(n)
  - function credit_bits(n)
  - localparam-style default widths for the message layout
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot grant and encoded grant ID.
- The top module holds the output register, ptr, inflight and the perf counters.

Test Plan:
- Reset: hold rst_n=0 with req_val=4'b1111 and cmp_val=1 → fu_val=0, req_rdy=0, inflight=0. First grant after release is requester 0.
- Round-robin fairness: req_val=4'b1111, fu_rdy=1, cmp_val pulsed each cycle starting one cycle after the first grant → fu_id sequence 0,1,2,3,0; each fu_msg equals that requester's payload.
- Backpressure: requester 2 alone, fu_rdy=0 for 3 cycles → fu_val=1 with fu_msg/fu_id stable and req_rdy=0. When fu_rdy=1, the next grant issues the same cycle.
- Credits: p_max_inflight=2, all requesting, fu_rdy=1, no cmp → exactly 2 grants, then req_rdy=0 and inflight=2. After a cmp_val with cmp_id=1 → cmp_out_val=4'b0010, and one more grant in the following cycle.
- Simultaneous grant and completion at inflight=1 → inflight stays 1. cmp_val at inflight=0 → inflight stays 0.
- Async reset mid-stream (rst_n low between edges with fu_val=1) → fu_val drops immediately; inflight=0 and ptr=0 after release.
